// File: rtl/core_wb_arbiter_if.sv
// Writeback handshake bundle: ALU and LSU result beats in, register-file write port out.
// Producers and the regfile side use the master modport; the arbiter uses the slave modport.
interface core_wb_arbiter_if;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd_addr;
    logic [31:0] alu_rd_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd_addr;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_byte_off;
    logic [2:0]  lsu_funct3;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    modport master (
        output alu_valid, alu_rd_addr, alu_rd_data,
        output lsu_valid, lsu_rd_addr, lsu_rdata, lsu_byte_off, lsu_funct3,
        input  alu_ready, lsu_ready, rd_we, rd_addr, rd_data
    );

    modport slave (
        input  alu_valid, alu_rd_addr, alu_rd_data,
        input  lsu_valid, lsu_rd_addr, lsu_rdata, lsu_byte_off, lsu_funct3,
        output alu_ready, lsu_ready, rd_we, rd_addr, rd_data
    );
endinterface

// File: rtl/core_wb_arbiter.sv
// Writeback arbiter: merges ALU/LSU beats into one registered regfile write, 1 cycle accept-to-write.
// LSU wins unless the ALU starves; regfile never stalls. CORE_WB_SKID_EN adds a 1-entry LSU skid.
module core_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    core_wb_arbiter_if.slave wb
);
    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_beat_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic       force_alu;
    logic       lsu_pend;
    logic       alu_grant;
    logic       lsu_grant;
    logic       out_vld;
    wb_beat_t   alu_beat;
    wb_beat_t   lsu_beat;
    wb_beat_t   out_beat;
    logic       rd_we_q;
    wb_beat_t   rd_q;

    // Shift is zero-filled, so a halfword at offset 3 picks up zeros in its top byte.
    function automatic logic [31:0] load_ext(input logic [31:0] raw,
                                             input logic [1:0]  off,
                                             input logic [2:0]  f3);
        logic [31:0] sh;
        sh = raw >> {off, 3'b000};
        case (f3)
            3'b000:  load_ext = {{24{sh[7]}}, sh[7:0]};
            3'b100:  load_ext = {24'h0, sh[7:0]};
            3'b001:  load_ext = {{16{sh[15]}}, sh[15:0]};
            3'b101:  load_ext = {16'h0, sh[15:0]};
            default: load_ext = raw;
        endcase
    endfunction

    assign alu_beat  = '{addr: wb.alu_rd_addr, data: wb.alu_rd_data};
    assign lsu_beat  = '{addr: wb.lsu_rd_addr,
                         data: load_ext(wb.lsu_rdata, wb.lsu_byte_off, wb.lsu_funct3)};
    assign force_alu = wb.alu_valid && (starve_cnt >= LIMIT);
    assign alu_grant = rst_n_i && wb.alu_valid && (force_alu || !lsu_pend);
    assign lsu_grant = rst_n_i && lsu_pend && !alu_grant;
    assign out_vld   = alu_grant || lsu_grant;
    assign wb.alu_ready = alu_grant;

`ifdef CORE_WB_SKID_EN
    logic     skid_full;
    wb_beat_t skid_beat;
    logic     lsu_take;

    // Ready depends only on skid state, never on this cycle's arbitration.
    assign wb.lsu_ready = rst_n_i && !skid_full;
    assign lsu_take     = rst_n_i && wb.lsu_valid && !skid_full;
    assign lsu_pend     = skid_full || wb.lsu_valid;
    assign out_beat     = alu_grant ? alu_beat : (skid_full ? skid_beat : lsu_beat);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            skid_full <= 1'b0;
            skid_beat <= '0;
        end else if (skid_full) begin
            if (lsu_grant) skid_full <= 1'b0;
        end else if (lsu_take && alu_grant) begin
            skid_full <= 1'b1;
            skid_beat <= lsu_beat;
        end
    end
`else
    assign wb.lsu_ready = lsu_grant;
    assign lsu_pend     = wb.lsu_valid;
    assign out_beat     = alu_grant ? alu_beat : lsu_beat;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            starve_cnt <= '0;
        end else if (alu_grant) begin
            starve_cnt <= '0;
        end else if (wb.alu_valid && starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // x0 beats are consumed but never raise the write enable.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rd_we_q <= 1'b0;
            rd_q    <= '0;
        end else begin
            rd_we_q <= out_vld && (out_beat.addr != 5'd0);
            if (out_vld) rd_q <= out_beat;
        end
    end

    assign wb.rd_we   = rd_we_q;
    assign wb.rd_addr = rd_q.addr;
    assign wb.rd_data = rd_q.data;
endmodule
